// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state encoding and default parameters for stopwatch_counter.
package stopwatch_pkg;
    typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_MAX_VAL = 9;
    localparam int DEF_PRESCALE = 1;
endpackage

// File: rtl/stopwatch_counter_edge_detect.sv
// edge_detect: registered rising-edge detector; the history register loads the input during reset.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic q;
    always_ff @(posedge clk) q <= d;
    assign rise = d & ~q & ~rst;
endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: start/stop/clear up/down modulo counter with prescaler and wrap pulse.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MAX_VAL = DEF_MAX_VAL,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SW1,
    input  logic             SW2,
    input  logic             DIR,
    output logic [WIDTH-1:0] OUT,
    output logic             RUN,
    output logic             CARRY
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);
    state_t state, state_nx;
    logic [PW-1:0] pre_cnt;
    logic [WIDTH-1:0] out_nx;
    logic sw1_edge, sw2_edge, tick, wrap;
    edge_detect u_sw1 (.clk(CLK), .rst(RST), .d(SW1), .rise(sw1_edge));
    edge_detect u_sw2 (.clk(CLK), .rst(RST), .d(SW2), .rise(sw2_edge));
    always_comb begin
        state_nx = sw1_edge ? (state == ST_RUN ? ST_STOP : ST_RUN) : state;
        tick = state == ST_RUN && pre_cnt == PRE_LAST;
        wrap = DIR ? OUT == '0 : OUT == TOP;
        out_nx = wrap ? (DIR ? TOP : '0) : (DIR ? OUT - WIDTH'(1) : OUT + WIDTH'(1));
    end
    // clear beats a coincident tick and also swallows its wrap pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_STOP;
            OUT <= '0;
            pre_cnt <= '0;
            CARRY <= 1'b0;
        end else begin
            state <= state_nx;
            CARRY <= tick && wrap && !sw2_edge;
            if (sw2_edge) begin
                OUT <= '0;
                pre_cnt <= '0;
            end else if (state == ST_RUN) begin
                pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
                if (tick) OUT <= out_nx;
            end
        end
    end
    assign RUN = state == ST_RUN;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed and random checks of two stopwatch_counter configurations against a behavioural model.
module tb_stopwatch_counter;
    logic CLK = 1'b0, RST = 1'b0, SW1 = 1'b0, SW2 = 1'b0, DIR = 1'b0;
    logic [3:0] a_out;
    logic [2:0] b_out;
    logic a_run, a_carry, b_run, b_carry;
    int checks = 0, failures = 0;
    int m_run[2], m_cnt[2], m_pre[2], m_carry[2];
    int mx[2] = '{9, 5};
    int ps[2] = '{1, 3};
    bit p1 = 0, p2 = 0;

    stopwatch_counter u_a (.CLK(CLK), .RST(RST), .SW1(SW1), .SW2(SW2), .DIR(DIR),
                           .OUT(a_out), .RUN(a_run), .CARRY(a_carry));
    stopwatch_counter #(.WIDTH(3), .MAX_VAL(5), .PRESCALE(3)) u_b (
        .CLK(CLK), .RST(RST), .SW1(SW1), .SW2(SW2), .DIR(DIR),
        .OUT(b_out), .RUN(b_run), .CARRY(b_carry));

    always #50 CLK = ~CLK;

    // advance the model by the inputs seen at the coming edge, then clock once
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                m_run[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_carry[i] = 0;
            end else begin
                m_carry[i] = 0;
                if (SW2 && !p2) begin
                    m_cnt[i] = 0; m_pre[i] = 0;
                end else if (m_run[i] != 0) begin
                    m_pre[i] = (m_pre[i] + 1) % ps[i];
                    if (m_pre[i] == 0) begin
                        m_carry[i] = DIR ? int'(m_cnt[i] == 0) : int'(m_cnt[i] == mx[i]);
                        m_cnt[i] = DIR ? (m_cnt[i] + mx[i]) % (mx[i] + 1) : (m_cnt[i] + 1) % (mx[i] + 1);
                    end
                end
                if (SW1 && !p1) m_run[i] = 1 - m_run[i];
            end
        end
        p1 = SW1; p2 = SW2;
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1; step(); step(); RST = 0;
    endtask

    task automatic test_reset();
        SW1 = 0; SW2 = 0; DIR = 0;
        do_reset();
        checks += 6;
        if (a_out !== 4'd0) begin failures++; $display("FAIL reset a_out got=%0d want=0", a_out); end
        if (a_run !== 1'b0) begin failures++; $display("FAIL reset a_run got=%0b want=0", a_run); end
        if (a_carry !== 1'b0) begin failures++; $display("FAIL reset a_carry got=%0b want=0", a_carry); end
        if (b_out !== 3'd0) begin failures++; $display("FAIL reset b_out got=%0d want=0", b_out); end
        if (b_run !== 1'b0) begin failures++; $display("FAIL reset b_run got=%0b want=0", b_run); end
        if (b_carry !== 1'b0) begin failures++; $display("FAIL reset b_carry got=%0b want=0", b_carry); end
    endtask

    task automatic test_count_up();
        SW1 = 1; step(); SW1 = 0;
        checks++;
        if (a_run !== 1'b1) begin failures++; $display("FAIL start a_run got=%0b want=1", a_run); end
        for (int i = 1; i <= 11; i++) begin
            step();
            checks += 3;
            if (a_out !== 4'(i % 10)) begin failures++; $display("FAIL count_up a_out step=%0d got=%0d want=%0d", i, a_out, i % 10); end
            if (a_carry !== (i == 10)) begin failures++; $display("FAIL count_up a_carry step=%0d got=%0b want=%0b", i, a_carry, i == 10); end
            if (b_out !== 3'(m_cnt[1])) begin failures++; $display("FAIL count_up b_out got=%0d want=%0d", b_out, m_cnt[1]); end
        end
    endtask

    task automatic test_stop_resume();
        int n = 0;
        while (a_out !== 4'd4 && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL stop_wait timeout a_out got=%0d want=4", a_out); end
        SW1 = 1; step(); SW1 = 0;
        checks += 2;
        if (a_run !== 1'b0) begin failures++; $display("FAIL stop a_run got=%0b want=0", a_run); end
        if (a_out !== 4'd5) begin failures++; $display("FAIL stop a_out got=%0d want=5", a_out); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks += 2;
            if (a_out !== 4'd5) begin failures++; $display("FAIL hold a_out got=%0d want=5", a_out); end
            if (a_carry !== 1'b0) begin failures++; $display("FAIL hold a_carry got=%0b want=0", a_carry); end
        end
        SW1 = 1; step(); SW1 = 0;
        for (int v = 6; v <= 7; v++) begin
            step();
            checks += 2;
            if (a_out !== 4'(v)) begin failures++; $display("FAIL resume a_out got=%0d want=%0d", a_out, v); end
            if (a_run !== 1'b1) begin failures++; $display("FAIL resume a_run got=%0b want=1", a_run); end
        end
    endtask

    task automatic test_down_clear();
        int n = 0;
        int exp_out[3] = '{0, 9, 8};
        int exp_c[3] = '{0, 1, 0};
        while (a_out !== 4'd1 && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL down_wait timeout a_out got=%0d want=1", a_out); end
        DIR = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 2;
            if (a_out !== 4'(exp_out[i])) begin failures++; $display("FAIL down a_out got=%0d want=%0d", a_out, exp_out[i]); end
            if (a_carry !== 1'(exp_c[i])) begin failures++; $display("FAIL down a_carry got=%0b want=%0d", a_carry, exp_c[i]); end
        end
        SW2 = 1; step(); SW2 = 0;
        checks += 4;
        if (a_out !== 4'd0) begin failures++; $display("FAIL clear a_out got=%0d want=0", a_out); end
        if (a_run !== 1'b1) begin failures++; $display("FAIL clear a_run got=%0b want=1", a_run); end
        if (a_carry !== 1'b0) begin failures++; $display("FAIL clear a_carry got=%0b want=0", a_carry); end
        if (b_out !== 3'(m_cnt[1])) begin failures++; $display("FAIL clear b_out got=%0d want=%0d", b_out, m_cnt[1]); end
        step();
        checks++;
        if (a_out !== 4'd9) begin failures++; $display("FAIL down_after_clear a_out got=%0d want=9", a_out); end
        DIR = 0;
    endtask

    task automatic test_prescale();
        int n = 0;
        logic [2:0] v;
        do_reset();
        SW1 = 1; step(); SW1 = 0;
        for (int j = 1; j <= 20; j++) begin
            step();
            checks += 2;
            if (b_out !== 3'((j / 3) % 6)) begin failures++; $display("FAIL prescale b_out j=%0d got=%0d want=%0d", j, b_out, (j / 3) % 6); end
            if (b_carry !== (j == 18)) begin failures++; $display("FAIL prescale b_carry j=%0d got=%0b want=%0b", j, b_carry, j == 18); end
        end
        while (m_pre[1] != 0 && n < 5) begin step(); n++; end
        SW1 = 1; step(); SW1 = 0;
        v = b_out;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (b_out !== v) begin failures++; $display("FAIL prescale_hold b_out got=%0d want=%0d", b_out, v); end
        end
        SW1 = 1; step(); SW1 = 0;
        step();
        checks++;
        if (b_out !== v) begin failures++; $display("FAIL prescale_resume_early b_out got=%0d want=%0d", b_out, v); end
        step();
        checks++;
        if (b_out !== 3'((v + 1) % 6)) begin failures++; $display("FAIL prescale_resume b_out got=%0d want=%0d", b_out, (v + 1) % 6); end
    endtask

    task automatic test_sw1_hold();
        do_reset();
        SW1 = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (a_run !== 1'b1) begin failures++; $display("FAIL sw1_hold a_run cycle=%0d got=%0b want=1", i, a_run); end
        end
        SW1 = 0; step();
        checks++;
        if (a_run !== 1'b1) begin failures++; $display("FAIL sw1_release a_run got=%0b want=1", a_run); end
    endtask

    task automatic test_reset_release();
        RST = 1; SW1 = 1; step(); step(); RST = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 2;
            if (a_run !== 1'b0) begin failures++; $display("FAIL rst_release a_run got=%0b want=0", a_run); end
            if (b_run !== 1'b0) begin failures++; $display("FAIL rst_release b_run got=%0b want=0", b_run); end
        end
        SW1 = 0; step();
    endtask

    task automatic test_rst_midcount();
        int n = 0;
        SW1 = 1; step(); SW1 = 0;
        while (a_out !== 4'd7 && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL rst_wait timeout a_out got=%0d want=7", a_out); end
        RST = 1; step(); RST = 0;
        checks += 3;
        if (a_out !== 4'd0) begin failures++; $display("FAIL rst_mid a_out got=%0d want=0", a_out); end
        if (a_run !== 1'b0) begin failures++; $display("FAIL rst_mid a_run got=%0b want=0", a_run); end
        if (a_carry !== 1'b0) begin failures++; $display("FAIL rst_mid a_carry got=%0b want=0", a_carry); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            SW1 = ($urandom % 6) == 0;
            SW2 = ($urandom % 25) == 0;
            if ($urandom % 10 == 0) DIR = ~DIR;
            RST = ($urandom % 300) == 0;
            step();
            checks += 6;
            if (a_out !== 4'(m_cnt[0])) begin failures++; $display("FAIL rand a_out i=%0d got=%0d want=%0d", i, a_out, m_cnt[0]); end
            if (a_run !== 1'(m_run[0])) begin failures++; $display("FAIL rand a_run i=%0d got=%0b want=%0d", i, a_run, m_run[0]); end
            if (a_carry !== 1'(m_carry[0])) begin failures++; $display("FAIL rand a_carry i=%0d got=%0b want=%0d", i, a_carry, m_carry[0]); end
            if (b_out !== 3'(m_cnt[1])) begin failures++; $display("FAIL rand b_out i=%0d got=%0d want=%0d", i, b_out, m_cnt[1]); end
            if (b_run !== 1'(m_run[1])) begin failures++; $display("FAIL rand b_run i=%0d got=%0b want=%0d", i, b_run, m_run[1]); end
            if (b_carry !== 1'(m_carry[1])) begin failures++; $display("FAIL rand b_carry i=%0d got=%0b want=%0d", i, b_carry, m_carry[1]); end
        end
        RST = 0; SW1 = 0; SW2 = 0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_carry[i] = 0;
        end
        test_reset();
        test_count_up();
        test_stop_resume();
        test_down_clear();
        test_prescale();
        test_sw1_hold();
        test_reset_release();
        test_rst_midcount();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
